// File: rtl/multicycle_ctrl.sv
// Control unit for a multicycle MIPS-subset datapath.
// It sequences FETCH/DECODE/EXEC/MEM/WB and decodes the datapath strobes from the current state and the latched instruction fields.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_sel,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        reg_we,
    output logic        branch_en,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op,
    output logic        reg_dst,
    output logic        wb_sel,
    output logic [2:0]  state,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count
);
    // The wait counter only has to hold MEM_TIMEOUT-1 before the fault fires.
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_ADDI    = 6'b001000;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_MEM     = 3'd4,
        S_WB      = 3'd5,
        S_HALT    = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE, C_LW, C_SW, C_BEQ, C_ADDI, C_J, C_SYSCALL, C_ILLEGAL
    } cls_t;

    function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE: return (fn == FN_SYSCALL) ? C_SYSCALL : C_RTYPE;
            OP_LW:    return C_LW;
            OP_SW:    return C_SW;
            OP_BEQ:   return C_BEQ;
            OP_ADDI:  return C_ADDI;
            OP_J:     return C_J;
            default:  return C_ILLEGAL;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [5:0]        opcode_q, opcode_d;
    logic [5:0]        funct_q, funct_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              fault_q, fault_d;
    logic [31:0]       instr_count_q, instr_count_d;
    logic              retire;
    cls_t              dec_cls, cur_cls;

    assign dec_cls = classify(opcode, funct);
    assign cur_cls = classify(opcode_q, funct_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            opcode_q      <= '0;
            funct_q       <= '0;
            wait_q        <= '0;
            fault_q       <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            funct_q       <= funct_d;
            wait_q        <= wait_d;
            fault_q       <= fault_d;
            instr_count_q <= instr_count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        funct_d   = funct_q;
        wait_d    = wait_q;
        fault_d   = fault_q;
        mem_req   = 1'b0;
        mem_sel   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        branch_en = 1'b0;
        pc_src    = 2'b00;
        alu_op    = 2'b00;
        reg_dst   = 1'b0;
        wb_sel    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                opcode_d = opcode;
                funct_d  = funct;
                case (dec_cls)
                    C_SYSCALL: state_d = S_HALT;
                    C_ILLEGAL: begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                    default:   state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cur_cls)
                    C_RTYPE: begin
                        alu_op  = 2'b10;
                        state_d = S_WB;
                    end
                    C_ADDI:  state_d = S_WB;
                    C_LW,
                    C_SW:    state_d = S_MEM;
                    C_BEQ: begin
                        alu_op    = 2'b01;
                        branch_en = 1'b1;
                        pc_src    = 2'b01;
                        state_d   = S_FETCH;
                    end
                    C_J: begin
                        pc_we   = 1'b1;
                        pc_src  = 2'b10;
                        state_d = S_FETCH;
                    end
                    // Only reachable if the latched fields were corrupted.
                    default: begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (cur_cls == C_SW);
                if (mem_ready) begin
                    state_d = (cur_cls == C_SW) ? S_FETCH : S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = (cur_cls == C_RTYPE);
                wb_sel  = (cur_cls == C_LW);
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: begin
                state_d = S_HALT;
                fault_d = 1'b1;
            end
        endcase

        // Each memory phase starts its timeout window fresh.
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
            wait_d = '0;
        end

        retire        = (state_d == S_FETCH) && (state_q inside {S_EXEC, S_MEM, S_WB});
        instr_count_d = (retire && instr_count_q != '1) ? instr_count_q + 32'd1 : instr_count_q;
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign fault       = fault_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level model expands programs into per-cycle expectations,
// a monitor compares every cycle's outputs against them.
module tb_multicycle_ctrl;
    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [5:0]  opcode = '0;
    logic [5:0]  funct = '0;
    logic        mem_req, mem_sel, mem_we, ir_we, pc_we, reg_we, branch_en;
    logic [1:0]  pc_src, alu_op;
    logic        reg_dst, wb_sel, halted, fault;
    logic [2:0]  state;
    logic [31:0] instr_count;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
        .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we), .branch_en(branch_en),
        .pc_src(pc_src), .alu_op(alu_op), .reg_dst(reg_dst), .wb_sel(wb_sel),
        .state(state), .halted(halted), .fault(fault), .instr_count(instr_count)
    );

    typedef struct packed {
        logic [2:0]  state;
        logic        mem_req;
        logic        mem_sel;
        logic        mem_we;
        logic        ir_we;
        logic        pc_we;
        logic        reg_we;
        logic        branch_en;
        logic [1:0]  pc_src;
        logic [1:0]  alu_op;
        logic        reg_dst;
        logic        wb_sel;
        logic        halted;
        logic        fault;
        logic [31:0] instr_count;
    } obs_t;

    typedef struct {
        logic       rst;
        logic       run;
        logic       mem_ready;
        logic [5:0] opcode;
        logic [5:0] funct;
        bit         chk;
        string      tag;
        obs_t       exp;
    } item_t;

    typedef enum int {K_R, K_LW, K_SW, K_BEQ, K_ADDI, K_J, K_SYS, K_BAD} kind_t;

    obs_t        got;
    item_t       plan[$];
    item_t       sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic [31:0] m_count = '0;
    logic        m_fault = 1'b0;
    bit          steady = 1'b0;

    assign got = {state, mem_req, mem_sel, mem_we, ir_we, pc_we, reg_we, branch_en,
                  pc_src, alu_op, reg_dst, wb_sel, halted, fault, instr_count};

    function automatic logic rbit();
        return steady ? 1'b1 : 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [5:0] j6();
        return 6'($urandom_range(0, 63));
    endfunction

    function automatic obs_t mk(input logic [2:0] st);
        obs_t o;
        o             = '0;
        o.state       = st;
        o.halted      = (st == 3'd6);
        o.fault       = m_fault;
        o.instr_count = m_count;
        return o;
    endfunction

    function automatic string diff_field(input obs_t a, input obs_t b);
        if (a.state !== b.state)         return "state";
        if (a.mem_req !== b.mem_req)     return "mem_req";
        if (a.mem_sel !== b.mem_sel)     return "mem_sel";
        if (a.mem_we !== b.mem_we)       return "mem_we";
        if (a.ir_we !== b.ir_we)         return "ir_we";
        if (a.pc_we !== b.pc_we)         return "pc_we";
        if (a.reg_we !== b.reg_we)       return "reg_we";
        if (a.branch_en !== b.branch_en) return "branch_en";
        if (a.pc_src !== b.pc_src)       return "pc_src";
        if (a.alu_op !== b.alu_op)       return "alu_op";
        if (a.reg_dst !== b.reg_dst)     return "reg_dst";
        if (a.wb_sel !== b.wb_sel)       return "wb_sel";
        if (a.halted !== b.halted)       return "halted";
        if (a.fault !== b.fault)         return "fault";
        return "instr_count";
    endfunction

    task automatic add(input logic r, input logic rn, input logic mr, input logic [5:0] op,
                       input logic [5:0] fn, input bit ck, input string tag, input obs_t e);
        item_t it;
        it.rst = r; it.run = rn; it.mem_ready = mr; it.opcode = op; it.funct = fn;
        it.chk = ck; it.tag = tag; it.exp = e;
        plan.push_back(it);
    endtask

    task automatic add_reset(input int n);
        add(1'b1, rbit(), rbit(), j6(), j6(), 1'b0, "reset", mk(3'd0));
        m_count = '0;
        m_fault = 1'b0;
        for (int i = 1; i < n; i++) add(1'b1, rbit(), rbit(), j6(), j6(), 1'b1, "reset", mk(3'd0));
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, rbit(), j6(), j6(), 1'b1, "idle", mk(3'd0));
        add(1'b0, 1'b1, rbit(), j6(), j6(), 1'b1, "idle-run", mk(3'd0));
    endtask

    task automatic add_halt(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b1, rbit(), j6(), j6(), 1'b1, "halt", mk(3'd6));
    endtask

    task automatic add_fetch(input int fw, input string tag);
        obs_t e;
        e = mk(3'd1);
        e.mem_req = 1'b1;
        for (int i = 0; i < fw; i++) add(1'b0, rbit(), 1'b0, j6(), j6(), 1'b1, tag, e);
        e.ir_we = 1'b1;
        e.pc_we = 1'b1;
        add(1'b0, rbit(), 1'b1, j6(), j6(), 1'b1, tag, e);
    endtask

    task automatic add_exec(input kind_t k, input string tag);
        obs_t e;
        e = mk(3'd3);
        case (k)
            K_R:   e.alu_op = 2'b10;
            K_BEQ: begin e.alu_op = 2'b01; e.branch_en = 1'b1; e.pc_src = 2'b01; end
            K_J:   begin e.pc_we = 1'b1; e.pc_src = 2'b10; end
            default: ;
        endcase
        add(1'b0, rbit(), rbit(), j6(), j6(), 1'b1, tag, e);
    endtask

    function automatic obs_t mem_obs(input kind_t k);
        obs_t e;
        e = mk(3'd4);
        e.mem_req = 1'b1;
        e.mem_sel = 1'b1;
        e.mem_we  = (k == K_SW);
        return e;
    endfunction

    task automatic add_instr(input kind_t k, input int fw, input int mw, input logic [5:0] bad_op = 6'h3F);
        logic [5:0] op, fn;
        string      tag;
        obs_t       e;
        tag = k.name();
        fn  = j6();
        case (k)
            K_R:    begin op = 6'h00; while (fn == 6'b001100) fn = j6(); end
            K_SYS:  begin op = 6'h00; fn = 6'b001100; end
            K_LW:   op = 6'h23;
            K_SW:   op = 6'h2B;
            K_BEQ:  op = 6'h04;
            K_ADDI: op = 6'h08;
            K_J:    op = 6'h02;
            default: op = bad_op;
        endcase
        add_fetch(fw, tag);
        add(1'b0, rbit(), rbit(), op, fn, 1'b1, tag, mk(3'd2));
        if (k == K_SYS || k == K_BAD) begin
            if (k == K_BAD) m_fault = 1'b1;
            return;
        end
        add_exec(k, tag);
        if (k == K_LW || k == K_SW) begin
            e = mem_obs(k);
            for (int i = 0; i < mw; i++) add(1'b0, rbit(), 1'b0, j6(), j6(), 1'b1, tag, e);
            add(1'b0, rbit(), 1'b1, j6(), j6(), 1'b1, tag, e);
        end
        if (k == K_LW || k == K_R || k == K_ADDI) begin
            e = mk(3'd5);
            e.reg_we  = 1'b1;
            e.reg_dst = (k == K_R);
            e.wb_sel  = (k == K_LW);
            add(1'b0, rbit(), rbit(), j6(), j6(), 1'b1, tag, e);
        end
        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
    endtask

    task automatic run_plan(input string name);
        int n;
        n = plan.size();
        foreach (plan[i]) sb.push_back(plan[i]);
        for (int i = 0; i < n; i++) begin
            rst       = plan[i].rst;
            run       = plan[i].run;
            mem_ready = plan[i].mem_ready;
            opcode    = plan[i].opcode;
            funct     = plan[i].funct;
            @(posedge clk);
            #1;
        end
        plan.delete();
        $display("[TB] %s: %0d cycles", name, n);
    endtask

    task automatic check(input string name, input logic [31:0] g, input logic [31:0] want);
        tests++;
        if (g !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, g, want);
        end
    endtask

    initial begin : monitor
        item_t it;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                if (it.chk) begin
                    tests++;
                    if (got !== it.exp) begin
                        fails++;
                        $display("FAIL %s cycle %0d %s: got %h, want %h",
                                 it.tag, cyc, diff_field(got, it.exp), got, it.exp);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        obs_t e;
        int   n;
        @(posedge clk);
        #1;

        // Straight-line program with memory always ready.
        steady = 1'b1;
        add_reset(2);
        add_idle(0);
        add_instr(K_ADDI, 0, 0);
        add_instr(K_LW, 0, 0);
        add_instr(K_SW, 0, 0);
        add_instr(K_BEQ, 0, 0);
        add_instr(K_J, 0, 0);
        add_instr(K_SYS, 0, 0);
        add_halt(3);
        run_plan("program");
        check("program count", instr_count, 32'd5);
        check("program halted", 32'(halted), 32'd1);
        check("program fault", 32'(fault), 32'd0);
        steady = 1'b0;

        // lw with three wait states in MEM.
        add_reset(2);
        add_idle(1);
        add_instr(K_LW, 0, 3);
        add_instr(K_SYS, 0, 0);
        add_halt(2);
        run_plan("lw wait");

        // FETCH timeout after one retired instruction.
        add_reset(2);
        add_idle(1);
        add_instr(K_ADDI, 0, 0);
        e = mk(3'd1);
        e.mem_req = 1'b1;
        for (int i = 0; i < int'(TO); i++) add(1'b0, rbit(), 1'b0, j6(), j6(), 1'b1, "fetch-timeout", e);
        m_fault = 1'b1;
        add_halt(3);
        run_plan("fetch timeout");
        check("timeout count", instr_count, 32'd1);
        check("timeout fault", 32'(fault), 32'd1);

        // Illegal opcode, run held high in HALT.
        add_reset(2);
        add_idle(0);
        add_instr(K_BAD, 1, 0, 6'b111111);
        add_halt(6);
        run_plan("illegal opcode");
        check("illegal state", 32'(state), 32'd6);

        // MEM timeout on a store.
        add_reset(2);
        add_idle(0);
        add_fetch(0, "sw-timeout");
        add(1'b0, rbit(), rbit(), 6'h2B, j6(), 1'b1, "sw-timeout", mk(3'd2));
        add_exec(K_SW, "sw-timeout");
        e = mem_obs(K_SW);
        for (int i = 0; i < int'(TO); i++) add(1'b0, rbit(), 1'b0, j6(), j6(), 1'b1, "sw-timeout", e);
        m_fault = 1'b1;
        add_halt(2);
        run_plan("mem timeout");

        // Random programs; each begins by resetting out of the previous HALT.
        for (int p = 0; p < 6; p++) begin
            add_reset(2);
            add_idle(int'($urandom_range(0, 2)));
            n = int'($urandom_range(5, 10));
            for (int i = 0; i < n; i++)
                add_instr(kind_t'($urandom_range(0, 5)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
            add_instr(K_SYS, int'($urandom_range(0, 2)), 0);
            add_halt(int'($urandom_range(1, 3)));
            run_plan($sformatf("random program %0d", p));
        end

        // Reset arriving mid-MEM while mem_ready completes the access.
        add_reset(2);
        add_idle(0);
        add_instr(K_ADDI, 1, 0);
        add_instr(K_R, 0, 0);
        add_fetch(0, "lw-rst");
        add(1'b0, rbit(), rbit(), 6'h23, j6(), 1'b1, "lw-rst", mk(3'd2));
        add_exec(K_LW, "lw-rst");
        e = mem_obs(K_LW);
        for (int i = 0; i < 2; i++) add(1'b0, rbit(), 1'b0, j6(), j6(), 1'b1, "lw-rst", e);
        add(1'b1, 1'b1, 1'b1, j6(), j6(), 1'b1, "rst-in-mem", e);
        m_count = '0;
        m_fault = 1'b0;
        for (int i = 0; i < 2; i++) add(1'b0, 1'b0, rbit(), j6(), j6(), 1'b1, "after-rst", mk(3'd0));
        run_plan("reset in mem");
        check("rst count", instr_count, 32'd0);
        check("rst mem_req", 32'(mem_req), 32'd0);

        // Saturation of the retired-instruction counter.
        add_reset(2);
        add(1'b0, 1'b0, rbit(), j6(), j6(), 1'b1, "idle", mk(3'd0));
        run_plan("pre-force");
        force dut.instr_count_q = 32'hFFFF_FFFF;
        m_count = 32'hFFFF_FFFF;
        add(1'b0, 1'b0, rbit(), j6(), j6(), 1'b1, "forced", mk(3'd0));
        run_plan("force");
        release dut.instr_count_q;
        add_idle(0);
        add_instr(K_R, 0, 0);
        add_instr(K_ADDI, 0, 1);
        add_instr(K_SYS, 0, 0);
        add_halt(2);
        run_plan("saturate");
        check("saturated count", instr_count, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, the maximum cycles to wait for mem_ready in one access before a fault.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port run  input  1  start request, sampled in IDLE only.
REQ-005 SHALL have port opcode  input  6  IR[31:26] from the datapath.
REQ-006 SHALL have port funct  input  6  IR[5:0] from the datapath.
REQ-007 SHALL have port mem_ready  input  1  memory completion for the current request.
REQ-008 SHALL have port mem_req  output  1  memory access request.
REQ-009 SHALL have port mem_sel  output  1  address source: 0=PC, 1=ALU result.
REQ-010 SHALL have port mem_we  output  1  store strobe, qualified by mem_req.
REQ-011 SHALL have port ir_we, pc_we, reg_we  output  1 each  IR, PC and register-file write enables.
REQ-012 SHALL have port branch_en  output  1  PC write conditional on ALU zero, gated in the datapath.
REQ-013 SHALL have port pc_src  output  2  00=PC+4, 01=branch target, 10=jump target.
REQ-014 SHALL have port alu_op  output  2  00=add, 01=sub, 10=use funct.
REQ-015 SHALL have ports reg_dst and wb_sel  output  1 each  reg_dst 0=rt, 1=rd; wb_sel 0=ALU, 1=memory data.
REQ-016 SHALL have port state  output  3  current FSM state for the LED debug display.
REQ-017 SHALL have ports halted and fault  output  1 each  halted: HALT state; fault: illegal opcode or memory timeout.
REQ-018 SHALL have port instr_count  output  32  retired-instruction counter.

Function
REQ-019 SHALL encode the states IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; code 7 SHALL go to HALT with fault=1.
REQ-020 SHALL decode the control outputs combinationally from the current state and the latched opcode/funct; every output not named for a state SHALL be 0.
REQ-021 IDLE SHALL move to FETCH when run=1 and SHALL hold otherwise.
REQ-022 FETCH SHALL drive mem_req=1 and mem_sel=0; on mem_ready=1 it SHALL drive ir_we=1, pc_we=1 and pc_src=00 in that same cycle, then move to DECODE.
REQ-023 DECODE SHALL latch opcode/funct internally and classify: R-type (000000), lw (100011), sw (101011), beq (000100), addi (001000), j (000010).
REQ-024 In DECODE, R-type with funct=001100 (syscall) SHALL go to HALT with fault=0; an unlisted opcode SHALL go to HALT with fault=1; all other classes SHALL go to EXEC.
REQ-025 EXEC SHALL drive alu_op as follows: 10 for R-type, 01 for beq, 00 for all other classes.
REQ-026 EXEC SHALL route by class: lw/sw to MEM; R-type/addi to WB; beq drives branch_en=1, pc_src=01 and goes to FETCH; j drives pc_we=1, pc_src=10 and goes to FETCH.
REQ-027 MEM SHALL drive mem_req=1, mem_sel=1 and mem_we=(sw); on mem_ready it SHALL go to FETCH for sw and to WB for lw.
REQ-028 WB SHALL drive reg_we=1 for one cycle, with reg_dst=1 for R-type and 0 otherwise, and wb_sel=1 for lw and 0 otherwise; WB SHALL then go to FETCH.
REQ-029 An instruction retires on the cycle of the transition into FETCH from EXEC, MEM or WB; instr_count SHALL then increment and SHALL saturate at 0xFFFFFFFF.
REQ-030 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0; reaching MEM_TIMEOUT without mem_ready SHALL go to HALT with fault=1.
REQ-031 mem_ready sampled outside FETCH/MEM SHALL be ignored.
REQ-032 HALT SHALL be absorbing until rst; run SHALL be ignored in HALT; halted=1 only in HALT.
REQ-033 Latency without wait states: j/beq 3 cycles, sw/R-type/addi 4 cycles, lw 5 cycles, each from FETCH entry to the next FETCH entry.

Reset
REQ-034 When rst=1 at a clock edge, state SHALL become IDLE and instr_count, the wait counter, fault and the latched opcode/funct SHALL become 0, overriding any transition in progress, including mid-MEM and in HALT.
REQ-035 During and after reset all write enables and mem_req SHALL be 0 until FETCH is entered.

Verification
REQ-036 Bench: rst, run=1, mem_ready=1 always, program addi;lw;sw;beq;j;syscall -> state sequence 1,2,3,5 / 1,2,3,4,5 / 1,2,3,4 / 1,2,3 / 1,2,3 / 1,2,6; instr_count=5; halted=1; fault=0.
REQ-037 Bench: lw with mem_ready delayed 3 cycles in MEM -> MEM held 4 cycles with mem_req=1, mem_sel=1, mem_we=0, then WB with reg_we=1, wb_sel=1, reg_dst=0.
REQ-038 Bench: mem_ready held 0 in FETCH -> after 255 cycles state=6, fault=1, instr_count unchanged.
REQ-039 Bench: opcode 111111 in DECODE -> next state 6, fault=1; run=1 held afterwards -> state stays 6.
REQ-040 Bench: rst=1 asserted for one cycle while in MEM -> next cycle state=0, instr_count=0, mem_req=0, fault=0.
REQ-041 Bench: force instr_count to 0xFFFFFFFF, retire one R-type -> instr_count remains 0xFFFFFFFF.
